// File: rtl/rr_grant_arbiter_pkg.sv
// Shared constants and state encoding for the four-way round-robin grant arbiter.
package rr_grant_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/week5_ex2_decoder_always.sv
// Behavioural 2-to-4 decoder: sel -> one-hot out, purely combinational.
module week5_ex2_decoder_always (
  input  logic [1:0] sel,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    case (sel)
      2'd0:    out = 4'b0001;
      2'd1:    out = 4'b0010;
      2'd2:    out = 4'b0100;
      default: out = 4'b1000;
    endcase
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin owner of a one-hot select bus; grant one edge after req seen in IDLE.
// Requesters hold by keeping req high; MAX_HOLD revokes, and every handover idles one cycle.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int                HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_LAST_I);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic              timeout_q, timeout_d;

  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   idx;
  logic              pick_found;
  logic [N_REQ-1:0]  dec_out;

  // First requester at or after ptr, wrapping through the 2-bit index.
  always_comb begin
    pick_id    = ptr_q;
    pick_found = 1'b0;
    idx        = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr_q + ID_W'(i);
      if (!pick_found && req[idx]) begin
        pick_id    = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
          state_d       = BUSY;
        end
      end
      default: begin
        if (!req[grant_id_q]) begin
          grant_valid_d = 1'b0;
          ptr_d         = grant_id_q + ID_W'(1);
          state_d       = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          grant_valid_d = 1'b0;
          timeout_d     = 1'b1;
          ptr_d         = grant_id_q + ID_W'(1);
          state_d       = IDLE;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  week5_ex2_decoder_always u_dec (
    .sel (grant_id_q),
    .out (dec_out)
  );

  assign grant       = grant_valid_q ? dec_out : '0;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed vector table plus hand sequences for timeout, release-at-limit and mid-grant reset.
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_grant_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] id;
    logic       to;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic v, input logic [1:0] i, input logic t);
    vec_t x;
    x.rst_n = r; x.req = q; x.grant = g; x.valid = v; x.id = i; x.to = t;
    return x;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    rst_n = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic v,
                           input logic [1:0] i, input logic t);
    check({tag, ".grant"},   {4'b0, grant},       {4'b0, g});
    check({tag, ".valid"},   {7'b0, grant_valid}, {7'b0, v});
    check({tag, ".id"},      {6'b0, grant_id},    {6'b0, i});
    check({tag, ".timeout"}, {7'b0, timeout},     {7'b0, t});
  endtask

  initial begin
    // reset held two edges, then round-robin with 2-cycle holds
    vecs[0]  = mk(0, 4'b1111, 4'b0000, 0, 2'd0, 0);
    vecs[1]  = mk(0, 4'b1111, 4'b0000, 0, 2'd0, 0);
    vecs[2]  = mk(1, 4'b1111, 4'b0001, 1, 2'd0, 0);
    vecs[3]  = mk(1, 4'b1111, 4'b0001, 1, 2'd0, 0);
    vecs[4]  = mk(1, 4'b1110, 4'b0000, 0, 2'd0, 0);
    vecs[5]  = mk(1, 4'b1111, 4'b0010, 1, 2'd1, 0);
    vecs[6]  = mk(1, 4'b1111, 4'b0010, 1, 2'd1, 0);
    vecs[7]  = mk(1, 4'b1101, 4'b0000, 0, 2'd1, 0);
    vecs[8]  = mk(1, 4'b1111, 4'b0100, 1, 2'd2, 0);
    vecs[9]  = mk(1, 4'b1111, 4'b0100, 1, 2'd2, 0);
    vecs[10] = mk(1, 4'b1011, 4'b0000, 0, 2'd2, 0);
    vecs[11] = mk(1, 4'b1111, 4'b1000, 1, 2'd3, 0);
    vecs[12] = mk(1, 4'b1111, 4'b1000, 1, 2'd3, 0);
    vecs[13] = mk(1, 4'b0111, 4'b0000, 0, 2'd3, 0);
    vecs[14] = mk(1, 4'b1111, 4'b0001, 1, 2'd0, 0);
    vecs[15] = mk(1, 4'b1111, 4'b0001, 1, 2'd0, 0);
    vecs[16] = mk(1, 4'b1110, 4'b0000, 0, 2'd0, 0);
    // pointer skip: owner 1 releases, ptr=2, req=1001 must pick 3 first
    vecs[17] = mk(1, 4'b0010, 4'b0010, 1, 2'd1, 0);
    vecs[18] = mk(1, 4'b0000, 4'b0000, 0, 2'd1, 0);
    vecs[19] = mk(1, 4'b1001, 4'b1000, 1, 2'd3, 0);
    vecs[20] = mk(1, 4'b0001, 4'b0000, 0, 2'd3, 0);
    vecs[21] = mk(1, 4'b0001, 4'b0001, 1, 2'd0, 0);
    vecs[22] = mk(1, 4'b0000, 4'b0000, 0, 2'd0, 0);
    vecs[23] = mk(1, 4'b0000, 4'b0000, 0, 2'd0, 0);

    rst_n = 1'b0;
    req   = 4'b0000;
    #2;

    for (int n = 0; n < NV; n++) begin
      step(vecs[n].rst_n, vecs[n].req);
      check_all($sformatf("vec%0d", n), vecs[n].grant, vecs[n].valid, vecs[n].id, vecs[n].to);
    end

    // Timeout: sole requester 0, ptr=1; 8 granted cycles then one revoke cycle, repeating.
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 4'b0001);
      if (k % 9 == 0) begin
        check($sformatf("to%0d.grant", k),   {4'b0, grant},   8'h00);
        check($sformatf("to%0d.timeout", k), {7'b0, timeout}, 8'h01);
      end else begin
        check($sformatf("to%0d.grant", k),   {4'b0, grant},   8'h01);
        check($sformatf("to%0d.timeout", k), {7'b0, timeout}, 8'h00);
      end
    end

    // Release exactly on the edge where the hold limit would fire.
    step(1'b1, 4'b0000);
    check_all("rel_idle", 4'b0000, 0, 2'd0, 0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b0001);
      check_all($sformatf("rel_hold%0d", k), 4'b0001, 1, 2'd0, 0);
    end
    step(1'b1, 4'b0000);
    check_all("rel_at_limit", 4'b0000, 0, 2'd0, 0);

    // Mid-grant reset, then re-arbitration from ptr=0.
    step(1'b1, 4'b0100);
    check_all("mr_grant", 4'b0100, 1, 2'd2, 0);
    step(1'b1, 4'b0100);
    check_all("mr_hold", 4'b0100, 1, 2'd2, 0);
    step(1'b0, 4'b0100);
    check_all("mr_reset", 4'b0000, 0, 2'd0, 0);
    step(1'b1, 4'b0100);
    check_all("mr_regrant", 4'b0100, 1, 2'd2, 0);
    step(1'b1, 4'b0000);
    check_all("mr_release", 4'b0000, 0, 2'd2, 0);
    // ptr now 3: req=1001 must pick 3 ahead of 0
    step(1'b1, 4'b1001);
    check_all("mr_ptr3", 4'b1000, 1, 2'd3, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
